// File: rtl/dram_ctl_pkg.sv
// Shared definitions for the DRAM controller and its configuration loader:
// config byte indices, flag bit positions and loader state encoding.
package dram_ctl_pkg;

  localparam logic [3:0] CFG_REFLO   = 4'd0;
  localparam logic [3:0] CFG_REFHI   = 4'd1;
  localparam logic [3:0] CFG_MODE    = 4'd2;
  localparam logic [3:0] CFG_SETUP   = 4'd3;
  localparam logic [3:0] CFG_HOLD    = 4'd4;
  localparam logic [3:0] CFG_RAS     = 4'd5;
  localparam logic [3:0] CFG_CAS     = 4'd6;
  localparam logic [3:0] CFG_RAS2CAS = 4'd7;
  localparam logic [3:0] CFG_RASPRE  = 4'd8;
  localparam logic [3:0] CFG_CASPRE  = 4'd9;
  localparam logic [3:0] CFG_FINAL   = 4'd10;

  // Flag positions inside the mode byte (byte 2)
  localparam logic [2:0] MODE_RDY_POL_BIT   = 3'd4;
  localparam logic [2:0] MODE_PAGE_BIT      = 3'd5;
  localparam logic [2:0] MODE_DSETUP_BIT    = 3'd6;
  localparam logic [2:0] MODE_DELAY_RDY_BIT = 3'd7;

  // Flag positions inside the final byte (byte 10)
  localparam logic [2:0] FIN_KEEP_UNLOCKED_BIT = 3'd0;
  localparam logic [2:0] FIN_A17_BIT           = 3'd1;
  localparam logic [2:0] FIN_PAUSE_REFRESH_BIT = 3'd7;

  typedef logic [2:0] ldr_state_t;

  localparam ldr_state_t LDR_WAIT   = 3'd0;
  localparam ldr_state_t LDR_SETUP  = 3'd1;
  localparam ldr_state_t LDR_STROBE = 3'd2;
  localparam ldr_state_t LDR_GAP    = 3'd3;
  localparam ldr_state_t LDR_DONE   = 3'd4;

endpackage

// File: rtl/dram_conf_rom.sv
// Combinational step -> configuration byte table built from the
// loader parameters.
module dram_conf_rom
  import dram_ctl_pkg::*;
#(
  parameter logic [15:0] REFRESH_INTERVAL = 16'd390,
  parameter logic [3:0]  COLUMN_BITS      = 4'd7,
  parameter logic        RDY_POL          = 1'b0,
  parameter logic        PAGE_MODE        = 1'b0,
  parameter logic        DATA_SETUP       = 1'b0,
  parameter logic        DELAY_RDY        = 1'b0,
  parameter logic [7:0]  D_SETUP          = 8'd1,
  parameter logic [7:0]  D_HOLD           = 8'd1,
  parameter logic [7:0]  D_RAS            = 8'd1,
  parameter logic [7:0]  D_CAS            = 8'd1,
  parameter logic [7:0]  D_RAS2CAS        = 8'd1,
  parameter logic [7:0]  D_RASPRE         = 8'd1,
  parameter logic [7:0]  D_CASPRE         = 8'd1,
  parameter logic        KEEP_UNLOCKED    = 1'b0,
  parameter logic        A17_MODE         = 1'b0,
  parameter logic        PAUSE_ON_REFRESH = 1'b0
) (
  input  logic [3:0] step,
  output logic [7:0] cfg_byte
);

  logic [7:0] mode_byte;
  logic [7:0] final_byte;

  always_comb begin
    mode_byte                     = '0;
    mode_byte[3:0]                = COLUMN_BITS;
    mode_byte[MODE_RDY_POL_BIT]   = RDY_POL;
    mode_byte[MODE_PAGE_BIT]      = PAGE_MODE;
    mode_byte[MODE_DSETUP_BIT]    = DATA_SETUP;
    mode_byte[MODE_DELAY_RDY_BIT] = DELAY_RDY;

    final_byte                        = '0;
    final_byte[FIN_KEEP_UNLOCKED_BIT] = KEEP_UNLOCKED;
    final_byte[FIN_A17_BIT]           = A17_MODE;
    final_byte[FIN_PAUSE_REFRESH_BIT] = PAUSE_ON_REFRESH;
  end

  always_comb begin
    cfg_byte = '0;
    case (step)
      CFG_REFLO:   cfg_byte = REFRESH_INTERVAL[7:0];
      CFG_REFHI:   cfg_byte = REFRESH_INTERVAL[15:8];
      CFG_MODE:    cfg_byte = mode_byte;
      CFG_SETUP:   cfg_byte = D_SETUP;
      CFG_HOLD:    cfg_byte = D_HOLD;
      CFG_RAS:     cfg_byte = D_RAS;
      CFG_CAS:     cfg_byte = D_CAS;
      CFG_RAS2CAS: cfg_byte = D_RAS2CAS;
      CFG_RASPRE:  cfg_byte = D_RASPRE;
      CFG_CASPRE:  cfg_byte = D_CASPRE;
      CFG_FINAL:   cfg_byte = final_byte;
      default:     cfg_byte = '0;
    endcase
  end

endmodule

// File: rtl/dram_config_loader.sv
// Plays the 11-byte configuration sequence into the DRAM controller after
// reset, then acts as a transparent host-to-controller bus path.
module dram_config_loader
  import dram_ctl_pkg::*;
#(
  parameter logic [15:0] REFRESH_INTERVAL = 16'd390,
  parameter logic [3:0]  COLUMN_BITS      = 4'd7,
  parameter logic        RDY_POL          = 1'b0,
  parameter logic        PAGE_MODE        = 1'b0,
  parameter logic        DATA_SETUP       = 1'b0,
  parameter logic        DELAY_RDY        = 1'b0,
  parameter logic [7:0]  D_SETUP          = 8'd1,
  parameter logic [7:0]  D_HOLD           = 8'd1,
  parameter logic [7:0]  D_RAS            = 8'd1,
  parameter logic [7:0]  D_CAS            = 8'd1,
  parameter logic [7:0]  D_RAS2CAS        = 8'd1,
  parameter logic [7:0]  D_RASPRE         = 8'd1,
  parameter logic [7:0]  D_CASPRE         = 8'd1,
  parameter logic        KEEP_UNLOCKED    = 1'b0,
  parameter logic        A17_MODE         = 1'b0,
  parameter logic        PAUSE_ON_REFRESH = 1'b0,
  parameter int unsigned STARTUP_CYCLES   = 8,
  parameter int unsigned GAP_CYCLES       = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_csn_i,
  input  logic        host_rwn_i,
  input  logic [17:0] host_addr_i,
  output logic        host_rdy_o,
  input  logic        reconf_i,
  output logic        ctl_csn_o,
  output logic        ctl_rwn_o,
  output logic        ctl_confn_o,
  output logic [17:0] ctl_addr_o,
  input  logic        ctl_rdy_i,
  output logic        cfg_done_o,
  output logic [3:0]  cfg_step_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  ldr_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       step;
  logic             pending;
  logic [7:0]       cfg_byte;
  logic             rdy_norm;
  logic             reconf_go;

  dram_conf_rom #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .COLUMN_BITS      (COLUMN_BITS),
    .RDY_POL          (RDY_POL),
    .PAGE_MODE        (PAGE_MODE),
    .DATA_SETUP       (DATA_SETUP),
    .DELAY_RDY        (DELAY_RDY),
    .D_SETUP          (D_SETUP),
    .D_HOLD           (D_HOLD),
    .D_RAS            (D_RAS),
    .D_CAS            (D_CAS),
    .D_RAS2CAS        (D_RAS2CAS),
    .D_RASPRE         (D_RASPRE),
    .D_CASPRE         (D_CASPRE),
    .KEEP_UNLOCKED    (KEEP_UNLOCKED),
    .A17_MODE         (A17_MODE),
    .PAUSE_ON_REFRESH (PAUSE_ON_REFRESH)
  ) u_conf_rom (
    .step     (step),
    .cfg_byte (cfg_byte)
  );

  assign rdy_norm = ctl_rdy_i ^ RDY_POL;

  // Restart is only safe between host accesses while the controller is ready
  assign reconf_go = KEEP_UNLOCKED && (state == LDR_DONE) && (reconf_i || pending)
                     && host_csn_i && rdy_norm;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= LDR_WAIT;
      cnt     <= '0;
      step    <= '0;
      pending <= 1'b0;
    end else begin
      case (state)
        LDR_WAIT: begin
          if (cnt == STARTUP_LAST) begin
            cnt   <= '0;
            state <= LDR_SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LDR_SETUP: state <= LDR_STROBE;
        LDR_STROBE: begin
          cnt   <= '0;
          state <= LDR_GAP;
        end
        LDR_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (step == CFG_FINAL) begin
              state <= LDR_DONE;
            end else begin
              step  <= step + 4'd1;
              state <= LDR_SETUP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LDR_DONE: begin
          if (reconf_go) begin
            state   <= LDR_SETUP;
            step    <= '0;
            pending <= 1'b0;
          end else if (KEEP_UNLOCKED && reconf_i) begin
            pending <= 1'b1;
          end
        end
        default: begin
          state   <= LDR_WAIT;
          cnt     <= '0;
          step    <= '0;
          pending <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ctl_csn_o   = 1'b1;
    ctl_rwn_o   = 1'b1;
    ctl_confn_o = 1'b1;
    ctl_addr_o  = '0;
    host_rdy_o  = 1'b0;
    cfg_done_o  = 1'b0;
    case (state)
      LDR_SETUP: begin
        ctl_addr_o  = {10'b0, cfg_byte};
        ctl_confn_o = 1'b0;
      end
      LDR_STROBE: begin
        ctl_addr_o  = {10'b0, cfg_byte};
        ctl_confn_o = 1'b0;
        ctl_csn_o   = 1'b0;
      end
      LDR_GAP: ctl_addr_o = {10'b0, cfg_byte};
      LDR_DONE: begin
        ctl_csn_o   = host_csn_i;
        ctl_rwn_o   = host_rwn_i;
        ctl_addr_o  = host_addr_i;
        ctl_confn_o = A17_MODE ? host_addr_i[17] : 1'b1;
        host_rdy_o  = rdy_norm;
        cfg_done_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cfg_step_o = step;

endmodule

// File: tb/tb_dram_config_loader.sv
// Randomized bench for dram_config_loader: two parameterisations share the
// same inputs and are compared every cycle against a schedule-based model.
module tb_dram_config_loader;

  localparam int unsigned S_A = 8;
  localparam int unsigned G_A = 2;
  localparam int unsigned S_B = 5;
  localparam int unsigned G_B = 3;
  localparam logic [7:0] BYTES_A [11] = '{8'h86, 8'h01, 8'h07, 8'h01, 8'h01, 8'h01,
                                          8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
  localparam logic [7:0] BYTES_B [11] = '{8'h34, 8'h12, 8'hB9, 8'h02, 8'h03, 8'h04,
                                          8'h05, 8'h06, 8'h07, 8'h08, 8'h83};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_csn = 1'b1;
  logic        host_rwn = 1'b1;
  logic [17:0] host_addr = '0;
  logic        reconf = 1'b0;
  logic        ctl_rdy = 1'b0;

  logic        host_rdy  [2];
  logic        ctl_csn   [2];
  logic        ctl_rwn   [2];
  logic        ctl_confn [2];
  logic [17:0] ctl_addr  [2];
  logic        cfg_done  [2];
  logic [3:0]  cfg_step  [2];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned pos  [2];
  bit          pend [2];

  always #5 clk = ~clk;

  dram_config_loader u_dut_a (
    .clk_i (clk), .rst_i (rst),
    .host_csn_i (host_csn), .host_rwn_i (host_rwn), .host_addr_i (host_addr),
    .host_rdy_o (host_rdy[0]), .reconf_i (reconf),
    .ctl_csn_o (ctl_csn[0]), .ctl_rwn_o (ctl_rwn[0]), .ctl_confn_o (ctl_confn[0]),
    .ctl_addr_o (ctl_addr[0]), .ctl_rdy_i (ctl_rdy),
    .cfg_done_o (cfg_done[0]), .cfg_step_o (cfg_step[0])
  );

  dram_config_loader #(
    .REFRESH_INTERVAL (16'h1234), .COLUMN_BITS (4'd9), .RDY_POL (1'b1),
    .PAGE_MODE (1'b1), .DATA_SETUP (1'b0), .DELAY_RDY (1'b1),
    .D_SETUP (8'd2), .D_HOLD (8'd3), .D_RAS (8'd4), .D_CAS (8'd5),
    .D_RAS2CAS (8'd6), .D_RASPRE (8'd7), .D_CASPRE (8'd8),
    .KEEP_UNLOCKED (1'b1), .A17_MODE (1'b1), .PAUSE_ON_REFRESH (1'b1),
    .STARTUP_CYCLES (S_B), .GAP_CYCLES (G_B)
  ) u_dut_b (
    .clk_i (clk), .rst_i (rst),
    .host_csn_i (host_csn), .host_rwn_i (host_rwn), .host_addr_i (host_addr),
    .host_rdy_o (host_rdy[1]), .reconf_i (reconf),
    .ctl_csn_o (ctl_csn[1]), .ctl_rwn_o (ctl_rwn[1]), .ctl_confn_o (ctl_confn[1]),
    .ctl_addr_o (ctl_addr[1]), .ctl_rdy_i (ctl_rdy),
    .cfg_done_o (cfg_done[1]), .cfg_step_o (cfg_step[1])
  );

  function automatic int unsigned s_of(input int unsigned d);
    return (d == 0) ? S_A : S_B;
  endfunction
  function automatic int unsigned w_of(input int unsigned d);
    return 2 + ((d == 0) ? G_A : G_B);
  endfunction
  function automatic int unsigned done_at(input int unsigned d);
    return s_of(d) + 11 * w_of(d);
  endfunction
  function automatic logic [7:0] byte_of(input int unsigned d, input int unsigned i);
    return (d == 0) ? BYTES_A[i] : BYTES_B[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model state is the cycle count along the write schedule; DONE parks it at the end
  task automatic model_advance();
    for (int unsigned d = 0; d < 2; d++) begin
      if (rst) begin
        pos[d]  = 0;
        pend[d] = 0;
      end else if (pos[d] >= done_at(d)) begin
        if (d == 1) begin
          if ((reconf || pend[d]) && host_csn && !ctl_rdy) begin
            pos[d]  = s_of(d);
            pend[d] = 0;
          end else if (reconf) begin
            pend[d] = 1;
          end
        end
      end else begin
        pos[d]++;
      end
    end
  endtask

  task automatic check_all();
    for (int unsigned d = 0; d < 2; d++) begin
      logic        e_csn, e_rwn, e_confn, e_rdy, e_done;
      logic [17:0] e_addr;
      logic [3:0]  e_step;
      bit          chk_addr;
      int unsigned q, idx, ph;
      string       n;
      n = (d == 0) ? "A" : "B";
      e_csn = 1; e_rwn = 1; e_confn = 1; e_rdy = 0; e_done = 0;
      e_addr = '0; e_step = '0; chk_addr = 1;
      if (pos[d] >= done_at(d)) begin
        e_csn   = host_csn;
        e_rwn   = host_rwn;
        e_addr  = host_addr;
        e_confn = (d == 1) ? host_addr[17] : 1'b1;
        e_rdy   = (d == 1) ? !ctl_rdy : ctl_rdy;
        e_done  = 1;
        e_step  = 4'd10;
      end else if (pos[d] >= s_of(d)) begin
        q   = pos[d] - s_of(d);
        idx = q / w_of(d);
        ph  = q % w_of(d);
        e_step = 4'(idx);
        if (ph < 2) begin
          e_addr  = {10'b0, byte_of(d, idx)};
          e_confn = 0;
          e_csn   = (ph == 1) ? 1'b0 : 1'b1;
        end else begin
          chk_addr = 0;
        end
      end
      chk({n, ".csn"},   32'(ctl_csn[d]),   32'(e_csn));
      chk({n, ".rwn"},   32'(ctl_rwn[d]),   32'(e_rwn));
      chk({n, ".confn"}, 32'(ctl_confn[d]), 32'(e_confn));
      chk({n, ".rdy"},   32'(host_rdy[d]),  32'(e_rdy));
      chk({n, ".done"},  32'(cfg_done[d]),  32'(e_done));
      chk({n, ".step"},  32'(cfg_step[d]),  32'(e_step));
      if (chk_addr) chk({n, ".addr"}, 32'(ctl_addr[d]), 32'(e_addr));
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_advance();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_host(input bit allow_reconf);
    host_csn  = 1'($urandom_range(0, 1));
    host_rwn  = 1'($urandom_range(0, 1));
    host_addr = 18'($urandom);
    ctl_rdy   = 1'($urandom_range(0, 1));
    reconf    = allow_reconf && ($urandom_range(0, 11) == 0);
  endtask

  initial begin
    int unsigned first_strobe, first_done, n_strobe;
    logic prev_csn, prev_confn;
    bit   redone;

    // Reset held with host activity on the inputs
    rst = 1;
    repeat (3) begin
      rand_host(0);
      run_cycle();
    end
    chk("rst.csn", 32'(ctl_csn[0]), 32'd1);
    chk("rst.step", 32'(cfg_step[0]), 32'd0);

    // Default sequence from reset release
    rst = 0;
    first_strobe = 0; first_done = 0; n_strobe = 0;
    prev_csn = ctl_csn[0]; prev_confn = ctl_confn[0];
    for (int unsigned k = 1; k <= 64; k++) begin
      rand_host(0);
      run_cycle();
      if (!ctl_csn[0] && !cfg_done[0]) begin
        n_strobe++;
        if (first_strobe == 0) first_strobe = k;
        chk("A.pre_csn", 32'(prev_csn), 32'd1);
        chk("A.pre_confn", 32'(prev_confn), 32'd0);
        if (n_strobe <= 11) chk("A.strobe_byte", 32'(ctl_addr[0][7:0]), 32'(BYTES_A[n_strobe-1]));
      end
      if (cfg_done[0] && first_done == 0) first_done = k;
      prev_csn = ctl_csn[0]; prev_confn = ctl_confn[0];
    end
    chk("A.first_strobe", first_strobe, 32'd9);
    chk("A.done_cycle", first_done, 32'd52);
    chk("A.n_strobe", n_strobe, 32'd11);

    // Passthrough with inverted RDY polarity and A17 on CONFn
    host_csn = 0; host_rwn = 0; host_addr = 18'h2ABCD; ctl_rdy = 0; reconf = 0;
    run_cycle();
    chk("B.pt_addr", 32'(ctl_addr[1]), 32'h2ABCD);
    chk("B.pt_rwn", 32'(ctl_rwn[1]), 32'd0);
    chk("B.pt_rdy", 32'(host_rdy[1]), 32'd1);
    chk("B.pt_confn17", 32'(ctl_confn[1]), 32'd1);
    chk("A.pt_rdy", 32'(host_rdy[0]), 32'd0);
    host_addr = 18'h0ABCD;
    run_cycle();
    chk("B.pt_confn0", 32'(ctl_confn[1]), 32'd0);
    chk("A.pt_confn", 32'(ctl_confn[0]), 32'd1);

    // Re-configuration requested mid-access is deferred
    host_csn = 0; reconf = 1; ctl_rdy = 0;
    run_cycle();
    reconf = 0;
    repeat (3) run_cycle();
    chk("B.defer_done", 32'(cfg_done[1]), 32'd1);
    chk("A.defer_done", 32'(cfg_done[0]), 32'd1);
    host_csn = 1;
    run_cycle();
    chk("B.restart_done", 32'(cfg_done[1]), 32'd0);
    chk("B.restart_step", 32'(cfg_step[1]), 32'd0);
    chk("B.restart_confn", 32'(ctl_confn[1]), 32'd0);
    chk("A.locked_done", 32'(cfg_done[0]), 32'd1);
    n_strobe = 0; redone = 0;
    for (int unsigned k = 0; k < 80 && !redone; k++) begin
      rand_host(0);
      run_cycle();
      if (!ctl_csn[1] && !cfg_done[1]) n_strobe++;
      if (cfg_done[1]) redone = 1;
    end
    chk("B.redone", 32'(redone), 32'd1);
    chk("B.re_strobes", n_strobe, 32'd11);

    // Random traffic with sporadic re-configuration requests
    for (int unsigned k = 0; k < 250; k++) begin
      rand_host(1);
      run_cycle();
    end

    // Reset in the middle of the sequence (step 5 gap on A)
    rst = 1; rand_host(0);
    run_cycle();
    rst = 0;
    for (int unsigned k = 0; k < 30; k++) begin
      rand_host(0);
      run_cycle();
    end
    chk("A.gap5_step", 32'(cfg_step[0]), 32'd5);
    chk("A.gap5_csn", 32'(ctl_csn[0]), 32'd1);
    rst = 1; rand_host(0);
    run_cycle();
    chk("A.mrst_step", 32'(cfg_step[0]), 32'd0);
    chk("A.mrst_addr", 32'(ctl_addr[0]), 32'd0);
    chk("A.mrst_confn", 32'(ctl_confn[0]), 32'd1);
    rst = 0;
    first_strobe = 0;
    for (int unsigned k = 1; k <= 60; k++) begin
      rand_host(0);
      run_cycle();
      if (!ctl_csn[0] && !cfg_done[0] && first_strobe == 0) begin
        first_strobe = k;
        chk("A.re_byte0", 32'(ctl_addr[0][7:0]), 32'h86);
      end
    end
    chk("A.re_first_strobe", first_strobe, 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
